// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: pxl_x/pxl_y scan counters, colour select/blanking, hsync/vsync and a frame tick.
// Colour and sync are registered one pixel behind the coordinate; no backpressure, everything stalls while pix_en is low.
module vga_scan_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic [11:0] bg_rgb,
    input  logic [3:0]  obj_red,
    input  logic [3:0]  obj_green,
    input  logic [3:0]  obj_blue,
    input  logic        obj_draw,
    output logic [31:0] pxl_x,
    output logic [31:0] pxl_y,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_last;
    logic          v_last;
    logic          active;
    logic          hs;
    logic          vs;
    logic [11:0]   pix_rgb;
    logic [11:0]   rgb_q;

    always_comb begin
        h_last  = (h_cnt == H_LAST);
        v_last  = (v_cnt == V_LAST);
        active  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs      = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        vs      = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        // Blanking wins over the object so partly off-screen objects never reach the DAC.
        pix_rgb = 12'h000;
        if (active) begin
            pix_rgb = obj_draw ? {obj_red, obj_green, obj_blue} : bg_rgb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            rgb_q       <= 12'h000;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && h_last && v_last;
            if (pix_en) begin
                // Flags and colour are taken from the position being left, so they align with obj_*.
                rgb_q <= pix_rgb;
                hsync <= hs ~^ SYNC_POL;
                vsync <= vs ~^ SYNC_POL;
                if (h_last) begin
                    h_cnt <= '0;
                    v_cnt <= v_last ? '0 : v_cnt + VW'(1);
                end else begin
                    h_cnt <= h_cnt + HW'(1);
                end
            end
        end
    end

    assign pxl_x = 32'(h_cnt);
    assign pxl_y = 32'(v_cnt);
    assign {vga_r, vga_g, vga_b} = rgb_q;
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: a full-size instance for line/colour/reset work and a shrunken active-high one for frame-level timing.
module tb_vga_scan_ctrl;
    typedef struct packed {
        int   ha; int hf; int hs; int hb;
        int   va; int vf; int vs; int vb;
        logic pol;
    } tim_t;

    localparam tim_t TA = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    localparam tim_t TB = '{16, 2, 4, 3, 8, 2, 2, 3, 1'b1};

    logic        clk = 1'b0;
    logic        reset, pix_en, obj_draw;
    logic [3:0]  obj_red, obj_green, obj_blue;
    logic [11:0] bg_rgb;
    logic        force_all;
    logic        chk_en;

    logic [31:0] pxl_x_a, pxl_y_a, pxl_x_b, pxl_y_b;
    logic        hsync_a, vsync_a, fs_a, hsync_b, vsync_b, fs_b;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_scan_ctrl u_a (
        .clk(clk), .reset(reset), .pix_en(pix_en), .bg_rgb(bg_rgb),
        .obj_red(obj_red), .obj_green(obj_green), .obj_blue(obj_blue), .obj_draw(obj_draw),
        .pxl_x(pxl_x_a), .pxl_y(pxl_y_a), .hsync(hsync_a), .vsync(vsync_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .frame_start(fs_a)
    );

    vga_scan_ctrl #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
    ) u_b (
        .clk(clk), .reset(reset), .pix_en(pix_en), .bg_rgb(bg_rgb),
        .obj_red(obj_red), .obj_green(obj_green), .obj_blue(obj_blue), .obj_draw(obj_draw),
        .pxl_x(pxl_x_b), .pxl_y(pxl_y_b), .hsync(hsync_b), .vsync(vsync_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .frame_start(fs_b)
    );

    function automatic int htot(input tim_t t);
        return t.ha + t.hf + t.hs + t.hb;
    endfunction

    function automatic int vtot(input tim_t t);
        return t.va + t.vf + t.vs + t.vb;
    endfunction

    // Expected {hsync, vsync, rgb} after the pixel with linear index n is shown.
    function automatic logic [13:0] model_pix(input tim_t t, input int n, input logic d,
                                              input logic [11:0] o, input logic [11:0] bg);
        int x, y;
        logic act, in_hs, in_vs;
        logic [11:0] c;
        x     = n % htot(t);
        y     = (n / htot(t)) % vtot(t);
        act   = (x < t.ha) && (y < t.va);
        in_hs = (x >= t.ha + t.hf) && (x < t.ha + t.hf + t.hs);
        in_vs = (y >= t.va + t.vf) && (y < t.va + t.vf + t.vs);
        c     = !act ? 12'h000 : (d ? o : bg);
        return {in_hs ? t.pol : ~t.pol, in_vs ? t.pol : ~t.pol, c};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pixel counts since reset plus expected registered outputs.
    int          n_a, n_b;
    logic [13:0] e_a, e_b;
    logic        efs_a, efs_b;

    always @(posedge clk) begin
        if (reset) begin
            n_a = 0; n_b = 0;
            e_a = {~TA.pol, ~TA.pol, 12'h000};
            e_b = {~TB.pol, ~TB.pol, 12'h000};
            efs_a = 1'b0; efs_b = 1'b0;
        end else begin
            efs_a = 1'b0; efs_b = 1'b0;
            if (pix_en) begin
                e_a = model_pix(TA, n_a, obj_draw, {obj_red, obj_green, obj_blue}, bg_rgb);
                e_b = model_pix(TB, n_b, obj_draw, {obj_red, obj_green, obj_blue}, bg_rgb);
                n_a++; n_b++;
                efs_a = (n_a % (htot(TA) * vtot(TA))) == 0;
                efs_b = (n_b % (htot(TB) * vtot(TB))) == 0;
            end
        end
    end

    // Drawing unit: follows the full-size scan position, one object pixel at (100,1).
    always @(negedge clk) begin
        if (force_all) begin
            obj_draw = 1'b1; {obj_red, obj_green, obj_blue} = 12'hFFF;
        end else if ((n_a % htot(TA)) == 100 && ((n_a / htot(TA)) % vtot(TA)) == 1) begin
            obj_draw = 1'b1; {obj_red, obj_green, obj_blue} = 12'hF00;
        end else begin
            obj_draw = 1'b0; {obj_red, obj_green, obj_blue} = 12'h000;
        end
    end

    int fs_clk_b = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_x",  pxl_x_a, 32'(n_a % htot(TA)));
            chk("a_y",  pxl_y_a, 32'((n_a / htot(TA)) % vtot(TA)));
            chk("a_hs", 32'(hsync_a), 32'(e_a[13]));
            chk("a_vs", 32'(vsync_a), 32'(e_a[12]));
            chk("a_rgb", 32'({r_a, g_a, b_a}), 32'(e_a[11:0]));
            chk("a_fs", 32'(fs_a), 32'(efs_a));
            chk("b_x",  pxl_x_b, 32'(n_b % htot(TB)));
            chk("b_y",  pxl_y_b, 32'((n_b / htot(TB)) % vtot(TB)));
            chk("b_hs", 32'(hsync_b), 32'(e_b[13]));
            chk("b_vs", 32'(vsync_b), 32'(e_b[12]));
            chk("b_rgb", 32'({r_b, g_b, b_b}), 32'(e_b[11:0]));
            chk("b_fs", 32'(fs_b), 32'(efs_b));
            if (fs_b) fs_clk_b++;
        end
    end

    int hs_low_a, first_low_x, vs_hi_b, nz_a, nz_b;

    task automatic pulses(input int k);
        repeat (k) begin
            @(negedge clk); pix_en = 1'b1;
            @(negedge clk); pix_en = 1'b0;
            if (!hsync_a) begin
                hs_low_a++;
                if (first_low_x < 0) first_low_x = int'(pxl_x_a);
            end
            if (vsync_b) vs_hi_b++;
            if ({r_a, g_a, b_a} != 12'h000) nz_a++;
            if ({r_b, g_b, b_b} != 12'h000) nz_b++;
        end
    endtask

    task automatic clear_stats();
        hs_low_a = 0; first_low_x = -1; vs_hi_b = 0; nz_a = 0; nz_b = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    int fs_base;

    initial begin
        reset = 1'b1; pix_en = 1'b0; bg_rgb = 12'h00F; force_all = 1'b0; chk_en = 1'b0;
        clear_stats();
        do_reset();
        chk_en = 1'b1;
        chk("rst_x", pxl_x_a, 32'd0);
        chk("rst_y", pxl_y_a, 32'd0);
        chk("rst_hs_a", 32'(hsync_a), 32'd1);
        chk("rst_vs_b", 32'(vsync_b), 32'd0);
        chk("rst_rgb", 32'({r_a, g_a, b_a}), 32'h000);

        // One full line with a 10-clk pix_en gap at x=300.
        pulses(300);
        repeat (10) begin
            @(negedge clk);
            chk("gate_x", pxl_x_a, 32'd300);
            chk("gate_rgb", 32'({r_a, g_a, b_a}), 32'h00F);
            chk("gate_hs", 32'(hsync_a), 32'd1);
            chk("gate_vs", 32'(vsync_a), 32'd1);
        end
        pulses(500);
        chk("line_wrap_x", pxl_x_a, 32'd0);
        chk("line_wrap_y", pxl_y_a, 32'd1);
        chk("hs_low_cnt", 32'(hs_low_a), 32'd96);
        chk("hs_first_x", 32'(first_low_x), 32'd657);

        // Colour select on line 1.
        pulses(101);
        chk("obj_pix", 32'({r_a, g_a, b_a}), 32'hF00);
        pulses(1);
        chk("bg_pix", 32'({r_a, g_a, b_a}), 32'h00F);

        // Reset mid-line at (321,1).
        pulses(219);
        chk("pre_rst_x", pxl_x_a, 32'd321);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("mid_rst_x", pxl_x_a, 32'd0);
        chk("mid_rst_y", pxl_y_a, 32'd0);
        chk("mid_rst_rgb", 32'({r_a, g_a, b_a}), 32'h000);
        chk("mid_rst_hs", 32'(hsync_a), 32'd1);
        chk("mid_rst_fs", 32'(fs_a), 32'd0);
        pulses(1);
        chk("post_rst_x", pxl_x_a, 32'd1);
        chk("post_rst_rgb", 32'({r_a, g_a, b_a}), 32'h00F);

        // Two small frames with an all-covering white object.
        do_reset();
        force_all = 1'b1;
        clear_stats();
        fs_base = fs_clk_b;
        pulses(750);
        @(negedge clk);
        chk("b_vs_pix", 32'(vs_hi_b), 32'd100);
        chk("b_visible", 32'(nz_b), 32'd256);
        chk("b_fs_clks", 32'(fs_clk_b - fs_base), 32'd2);
        chk("a_visible", 32'(nz_a), 32'd640);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
- Display-side end of the object drawing interface: generates the pxl_x/pxl_y scan coordinates that every drawing unit consumes, and collects each unit's Red/Green/Blue/Draw reply.
- Composes the final pixel and drives the VGA connector: RGB plus hsync/vsync.
- Handles a single object channel plus a background colour; multi-object priority muxing sits upstream and presents one channel here.
- Also emits a frame-start strobe that the movement logic uses as its per-frame tick.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_en  in  1  pixel-rate enable; one-clk pulse, at most every 2nd clk
- bg_rgb  in  12  background colour {R[3:0],G[3:0],B[3:0]}
- obj_red  in  4  object red level from drawing unit
- obj_green  in  4  object green level
- obj_blue  in  4  object blue level
- obj_draw  in  1  object covers current coordinate
- pxl_x  out  32  current column, 0..H_TOTAL-1, zero-extended
- pxl_y  out  32  current line, 0..V_TOTAL-1, zero-extended
- hsync  out  1  horizontal sync to connector
- vsync  out  1  vertical sync to connector
- vga_r  out  4  red to DAC
- vga_g  out  4  green to DAC
- vga_b  out  4  blue to DAC
- frame_start  out  1  one-clk pulse at start of each frame

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Internal counters are sized to fit the totals, and pxl_x/pxl_y are zero-extended to 32 bits.
- Reset (sampled on clk) forces the following, regardless of pix_en:
  - h_cnt=0, v_cnt=0, so pxl_x=0 and pxl_y=0
  - hsync=vsync=!SYNC_POL (deasserted)
  - vga_r/g/b=0
  - frame_start=0
  - pipeline stage cleared
- Counters change only on clk edges where pix_en=1.
  - h_cnt increments.
  - At h_cnt=H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At v_cnt=V_TOTAL-1 with h_cnt=H_TOTAL-1, both wrap to 0.
- pxl_x/pxl_y are direct register outputs of h_cnt/v_cnt; there is no combinational path from any input.
- Drawing-unit contract: obj_* must reflect the current pxl_x/pxl_y before the next pix_en. Units with one registered stage qualify because pix_en spacing is at least 2 clks.
- Stage 1: on each pix_en, capture the current position's active flag, hsync flag and vsync flag into a delay register. Definitions:
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
  - hs = H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC
  - vs = V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC
- Stage 2 happens on the same pix_en edge, using the obj_* values sampled for the same position as the stage-1 flags:
  - vga_rgb = !active ? 0 : obj_draw ? {obj_red,obj_green,obj_blue} : bg_rgb
  - hsync/vsync = stage-1 flag XNOR SYNC_POL, so the asserted level equals SYNC_POL.
- Net latency: one pixel period from coordinate to DAC for colour and sync alike, so they stay aligned.
- Blanking: outside the active region, vga_r/g/b are forced to 0 even if obj_draw=1 (objects partly off-screen).
- frame_start asserts for exactly one clk, on the pix_en edge where counters move from (H_TOTAL-1, V_TOTAL-1) to (0,0). It does not fire on the reset release itself.
- pix_en=0: every register holds its value, so outputs are static.
- Reset asserted mid-line or mid-frame: restarts cleanly at (0,0) on the next clk. There is no partial-frame frame_start, and the first post-reset sync pulse follows normal timing.
- bg_rgb is sampled per pixel, so changing it takes effect on the next pix_en.

Test Plan:
1. Reset, then pix_en every 2nd clk for one full line:
   - pxl_x steps 0..799 then back to 0
   - pxl_y goes 0→1 on the wrap
   - hsync low for exactly 96 pixel periods, starting at the output pixel after x=655 (one period lag)
2. Full-frame run of 420000 pix_en:
   - vsync low for exactly 2 lines (y 490..491, lagged one pixel)
   - frame_start pulses once per 420000 pix_en and is exactly 1 clk wide
3. Colour select:
   - at (100,50): obj_draw=1, obj=F/0/0, bg=0x00F → vga=F/0/0 one pixel later
   - obj_draw=0 → vga=0/0/F
4. Blanking override: obj_draw=1, obj=FFF held constant → vga=000 for every output pixel whose source x≥640 or y≥480.
5. Reset mid-frame at (321,200):
   - next clk: pxl_x=pxl_y=0, vga=0, syncs deasserted, no frame_start
   - normal timing resumes on the following pix_en
6. pix_en gated low for 10 clks mid-line → pxl_x, vga_*, hsync and vsync unchanged for all 10 clks.
